// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state type and default widths for mem_ctrl
package mem_ctrl_pkg;
    localparam int MEM_CTRL_ADDR_W = 6;
    localparam int MEM_CTRL_DATA_W = 16;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RSP, CLEAR} mem_ctrl_state_t;
endpackage

// File: rtl/mem_clr_seq.sv
// mem_clr_seq: zero-fill sweep address counter and done-pulse generator
module mem_clr_seq
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_CTRL_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  active,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  done
);
    localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};
    logic [ADDR_WIDTH:0] cnt;
    assign addr = cnt[ADDR_WIDTH-1:0];
    assign last = active && cnt == LAST_CNT;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            cnt  <= start ? '0 : active ? cnt + 1'b1 : cnt;
            done <= last;
        end
    end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: valid/ready front end for a 1-cycle-latency sync memory; MEM_CTRL_CLEAR_EN adds a zero-fill sweep
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_CTRL_ADDR_W,
    parameter int DATA_WIDTH = MEM_CTRL_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    mem_ctrl_state_t state, state_nxt;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  clr_go, clr_active, clr_last;
    logic [ADDR_WIDTH-1:0] clr_addr;
`ifdef MEM_CTRL_CLEAR_EN
    assign clr_go     = state == IDLE && clr_start;
    assign clr_active = state == CLEAR;
    mem_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (clr_go),
        .active (clr_active),
        .addr   (clr_addr),
        .last   (clr_last),
        .done   (clr_done)
    );
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clr_go     = 1'b0;
    assign clr_active = 1'b0;
    assign clr_last   = 1'b0;
    assign clr_addr   = '0;
    assign clr_done   = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (req_valid && req_ready) begin
                cmd_we    <= req_we;
                cmd_addr  <= req_addr;
                cmd_wdata <= req_wdata;
            end
            if (state == WAIT) rsp_rdata <= mem_rdata;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = clr_go ? CLEAR : req_valid ? ISSUE : IDLE;
            ISSUE:   state_nxt = cmd_we ? IDLE : WAIT;
            WAIT:    state_nxt = RSP;
            RSP:     state_nxt = rsp_ready ? IDLE : RSP;
            CLEAR:   state_nxt = clr_last ? IDLE : CLEAR;
            default: state_nxt = IDLE;
        endcase
    end
    // Memory pins come only from registers, so req_* never reach mem_* combinationally
    always_comb begin
        req_ready = state == IDLE && !clr_go;
        rsp_valid = state == RSP;
        clr_busy  = clr_active;
        mem_we    = (state == ISSUE && cmd_we) || clr_active;
        mem_addr  = clr_active ? clr_addr : cmd_addr;
        mem_wdata = clr_active ? '0 : cmd_wdata;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with an attached 1-cycle sync memory
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        clr_start = 1'b0, clr_busy, clr_done;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    logic [15:0] exp_q [$];
    int n_tests = 0, n_fail = 0, n_rd = 0, n_rsp = 0, cyc = 0, acc_cyc = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_data", rsp_rdata, exp_q.pop_front());
        end
    end

    task automatic send(input logic we, input logic [5:0] a, input logic [15:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) begin
            check("req_timeout", 0, 1);
        end else begin
            acc_cyc = cyc;
            if (we) ref_mem[a] = d;
            else begin exp_q.push_back(ref_mem[a]); n_rd++; end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_req_ready"}, req_ready, 1);
        check({p, "_rsp_valid"}, rsp_valid, 0);
        check({p, "_rsp_rdata"}, rsp_rdata, 0);
        check({p, "_mem_we"}, mem_we, 0);
        check({p, "_mem_addr"}, mem_addr, 0);
        check({p, "_mem_wdata"}, mem_wdata, 0);
        check({p, "_clr_busy"}, clr_busy, 0);
        check({p, "_clr_done"}, clr_done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, nb, nd, done_at, rdy_at_done, start_cyc;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst0");

        send(1'b1, 6'h05, 16'h1234);
        @(negedge clk);
        check("wr_c1_mem_we", mem_we, 1);
        check("wr_c1_mem_addr", mem_addr, 6'h05);
        check("wr_c1_mem_wdata", mem_wdata, 16'h1234);
        check("wr_c1_req_ready", req_ready, 0);
        @(negedge clk);
        check("wr_c2_req_ready", req_ready, 1);
        check("wr_c2_mem_we", mem_we, 0);

        send(1'b0, 6'h05, '0);
        @(negedge clk); check("rd_c1_valid", rsp_valid, 0);
        @(negedge clk); check("rd_c2_valid", rsp_valid, 0);
        @(negedge clk); check("rd_c3_valid", rsp_valid, 1);
        @(negedge clk);
        check("rd_c4_ready", req_ready, 1);
        check("rd_c4_valid", rsp_valid, 0);

        send(1'b1, 6'h0A, 16'h5A5A);
        @(posedge clk); #1 rsp_ready = 1'b0;
        send(1'b0, 6'h0A, '0);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 16'h5A5A);
            check("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_single", rsp_valid, 0);

        send(1'b1, 6'h0C, 16'h7777);
        send(1'b0, 6'h0C, '0);
        @(posedge clk); #1 rst = 1'b1;
        void'(exp_q.pop_back());
        n_rd--;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        bad = 0;
        repeat (8) begin @(negedge clk); if (rsp_valid) bad++; end
        check("rst_no_rsp", bad, 0);
        send(1'b0, 6'h0C, '0);

`ifdef MEM_CTRL_CLEAR_EN
        send(1'b1, 6'h3F, 16'hBEEF);
        @(posedge clk); #1 clr_start = 1'b1;
        @(negedge clk);
        check("clr_c0_req_ready", req_ready, 0);
        @(posedge clk); #1 clr_start = 1'b0;
        nb = 0; nd = 0; done_at = 0; rdy_at_done = 0; bad = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (clr_busy) begin
                nb++;
                if (mem_we !== 1'b1 || mem_addr !== 6'(c - 1) || mem_wdata !== 16'h0) bad++;
            end
            if (clr_done) begin nd++; done_at = c; rdy_at_done = req_ready; end
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        check("clr_busy_cycles", nb, 64);
        check("clr_done_count", nd, 1);
        check("clr_done_cycle", done_at, 65);
        check("clr_done_ready", rdy_at_done, 1);
        check("clr_writes", bad, 0);
        send(1'b0, 6'h3F, '0);

        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        start_cyc = 0;
        fork
            send(1'b1, 6'h01, 16'hAAAA);
            begin
                @(posedge clk); #1;
                clr_start = 1'b1; start_cyc = cyc;
                @(posedge clk); #1 clr_start = 1'b0;
            end
        join
        check("prio_accept_cycle", acc_cyc - start_cyc, 65);
        send(1'b0, 6'h01, '0);
        send(1'b0, 6'h05, '0);

        send(1'b0, 6'h3F, '0);
        clr_start = 1'b1;
        @(posedge clk); #1 clr_start = 1'b0;
        bad = 0;
        repeat (6) begin @(negedge clk); if (clr_busy) bad++; end
        check("clr_ignored_busy", bad, 0);
`else
        send(1'b1, 6'h02, 16'h1357);
        @(posedge clk); #1 clr_start = 1'b1;
        @(negedge clk);
        check("noclr_req_ready", req_ready, 1);
        @(posedge clk); #1 clr_start = 1'b0;
        bad = 0;
        repeat (70) begin @(negedge clk); if (clr_busy || clr_done || mem_we) bad++; end
        check("noclr_quiet", bad, 0);
        send(1'b0, 6'h02, '0);
`endif
        repeat (6) @(negedge clk);
        check("rsp_count", n_rsp, n_rd);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Request-side controller that sits directly upstream of the single-port synchronous memory and owns its `we`/`addr`/`data` inputs and its `out` read port. Client reads and writes arrive over a valid/ready handshake. The block sequences each access against the memory's one-cycle read latency and returns read data over a valid/ready response channel with backpressure. An optional sweep engine zero-fills the whole memory on command.

## Interface
- `ADDR_WIDTH`, 6, memory address width; the memory holds 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 16, memory word width.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  request address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  client accepts the response.
- `rsp_rdata`  out  DATA_WIDTH  read data.
- `clr_start`  in  1  pulse that starts a zero-fill sweep.
- `clr_busy`  out  1  sweep in progress.
- `clr_done`  out  1  one-cycle pulse when the sweep finishes.
- `mem_we`  out  1  to memory `we`.
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`.
- `mem_wdata`  out  DATA_WIDTH  to memory `data`.
- `mem_rdata`  in  DATA_WIDTH  from memory `out`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RSP, CLEAR.
- `req_ready` = (state == IDLE) and not (clr_start accepted this cycle).
- **IDLE**
  - On handshake, register `req_we`/`req_addr`/`req_wdata` onto `mem_we`/`mem_addr`/`mem_wdata`, then go to ISSUE.
- **ISSUE**
  - The memory samples the registered command at the closing edge.
  - Write: `mem_we` clears on the next edge and the FSM returns to IDLE.
  - Read: `mem_we` is 0; go to WAIT.
- **WAIT**
  - `mem_rdata` is valid in this cycle.
  - At the closing edge, load it into the `rsp_rdata` register and go to RSP.
- **RSP**
  - `rsp_valid` = 1.
  - `rsp_rdata` is held stable until `rsp_valid && rsp_ready`; then go to IDLE.
- **Outside ISSUE and CLEAR**
  - `mem_we` = 0.
  - `mem_addr` holds its last value, so the memory is never re-read between accesses.
- **CLEAR**
  - Entered from IDLE on `clr_start`.
  - `clr_start` has priority over a simultaneous `req_valid`; that request is not accepted and stays pending.
  - Write 0 to address 0, 1, …, 2**ADDR_WIDTH−1, one per cycle, with `mem_we` = 1.
  - `clr_busy` = 1 throughout.
  - After the last address, go to IDLE and pulse `clr_done`.
  - The address counter is ADDR_WIDTH+1 bits wide so the sweep terminates after exactly 2**ADDR_WIDTH writes.
- `clr_start` outside IDLE is ignored and is not queued.
- **Reset values**: state IDLE, `req_ready` 1 (first cycle after reset), `rsp_valid` 0, `rsp_rdata` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `clr_busy` 0, `clr_done` 0.
- **Reset mid-operation**:
  - Any in-flight read or pending response is discarded with no `rsp_valid`.
  - A sweep is aborted; memory contents are left partially cleared and `clr_done` is not pulsed.

## Timing
- Request accepted in cycle 0:
  - Memory write takes effect at the end of cycle 1.
  - `req_ready` rises again in cycle 2.
- Read:
  - `rsp_valid` first high in cycle 3.
  - Minimum request-to-request spacing is 4 cycles with `rsp_ready` held at 1.
- Sweep started in cycle 0:
  - Writes occur in cycles 1 … 2**ADDR_WIDTH.
  - `clr_done` is high in cycle 2**ADDR_WIDTH+1, the same cycle `req_ready` returns.
- No combinational path from `req_*` or `rsp_ready` to `mem_*`.
- `rsp_ready` → state is registered only.

## Configuration
- `MEM_CTRL_CLEAR_EN` defined:
  - The CLEAR state and sweep counter are built.
  - Behaviour is as described above.
- Undefined:
  - The ports remain.
  - `clr_start` is ignored.
  - `clr_busy` and `clr_done` are tied to 0.
  - No CLEAR state or counter logic exists.

## Structure
- `mem_ctrl_pkg` holds:
  - the FSM state enum `mem_ctrl_state_t`;
  - default width constants `MEM_CTRL_ADDR_W` = 6 and `MEM_CTRL_DATA_W` = 16.
- One sub-module, `mem_clr_seq`:
  - holds the sweep counter and done-pulse generator;
  - is instantiated only under `MEM_CTRL_CLEAR_EN`.
- The FSM and datapath registers stay in `mem_ctrl`.

## Test plan
- Write 0x1234 to 0x05, then read 0x05 → `rsp_valid` in cycle 3 after the read is accepted, `rsp_rdata` = 0x1234.
- Read 0x0A with `rsp_ready` held low for 5 cycles → `rsp_valid` and `rsp_rdata` stable throughout, `req_ready` = 0, a single handshake on release.
- Write 0xBEEF to 0x3F, pulse `clr_start` → `clr_busy` high exactly 64 cycles, then `clr_done` pulses once; reading 0x3F returns 0x0000.
- `clr_start` and `req_valid` (write 0xAAAA @ 0x01) in the same cycle → sweep runs first, then the write is accepted; a later read of 0x01 returns 0xAAAA.
- `rst` asserted in the WAIT state of a read → no `rsp_valid` ever appears; all outputs at reset values the next cycle; `req_ready` = 1.
- Without `MEM_CTRL_CLEAR_EN`: pulse `clr_start` → `clr_busy` and `clr_done` stay 0, `mem_we` stays 0, a prior write to 0x02 survives.
